// File: rtl/signed_div_8x4.sv
// signed_div_8x4: sequential 8-by-4 signed restoring divider, one quotient bit per clock.
// Quotient truncates toward zero; the remainder takes the sign of the dividend.
module signed_div_8x4 (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] a,
    input  logic [3:0] b,
    output logic       busy,
    output logic       done,
    output logic [7:0] q,
    output logic [3:0] r,
    output logic       dz,
    output logic       ovf
);
    typedef enum logic [1:0] {IDLE, ITER, FIX} state_t;
    state_t state_q, state_d;
    logic [7:0] dvd_q, dvd_d, q_q, q_d, q_res;
    logic [3:0] dvs_q, dvs_d, r_q, r_d, r_res;
    logic [4:0] rem_q, rem_d, shl;
    logic [5:0] trial;
    logic [2:0] cnt_q, cnt_d;
    logic qneg_q, qneg_d, rneg_q, rneg_d, dzp_q, dzp_d, ovfp_q, ovfp_d;
    logic done_q, done_d, dz_q, dz_d, ovf_q, ovf_d;
    logic accept, fix;

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q == IDLE ? (start ? ITER : IDLE) :
                  state_q == ITER ? (cnt_q == 3'd7 ? FIX : ITER) : IDLE;
    end

    always_comb begin
        busy   = state_q != IDLE;
        accept = state_q == IDLE && start;
        fix    = state_q == FIX;
    end

    // dvd_q shifts dividend bits out the top while quotient bits enter at the bottom
    always_comb begin
        shl    = {rem_q[3:0], dvd_q[7]};
        trial  = {1'b0, shl} - {2'b00, dvs_q};
        dvd_d  = accept ? (a[7] ? -a : a) : state_q == ITER ? {dvd_q[6:0], ~trial[5]} : dvd_q;
        rem_d  = accept ? 5'd0 : state_q == ITER ? (trial[5] ? shl : trial[4:0]) : rem_q;
        dvs_d  = accept ? (b[3] ? -b : b) : dvs_q;
        cnt_d  = accept ? 3'd0 : state_q == ITER ? cnt_q + 3'd1 : cnt_q;
        qneg_d = accept ? a[7] ^ b[3] : qneg_q;
        rneg_d = accept ? a[7] : rneg_q;
        dzp_d  = accept ? b == 4'h0 : dzp_q;
        ovfp_d = accept ? (a == 8'h80 && b == 4'hF) : ovfp_q;
        q_res  = dzp_q ? 8'hFF : ovfp_q ? 8'h80 : qneg_q ? -dvd_q : dvd_q;
        r_res  = (dzp_q || ovfp_q) ? 4'h0 : rneg_q ? -rem_q[3:0] : rem_q[3:0];
        q_d    = fix ? q_res : q_q;
        r_d    = fix ? r_res : r_q;
        dz_d   = fix ? dzp_q : dz_q;
        ovf_d  = fix ? ovfp_q : ovf_q;
        done_d = fix;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dvd_q  <= 8'h00;
            rem_q  <= 5'd0;
            dvs_q  <= 4'h0;
            cnt_q  <= 3'd0;
            qneg_q <= 1'b0;
            rneg_q <= 1'b0;
            dzp_q  <= 1'b0;
            ovfp_q <= 1'b0;
            q_q    <= 8'h00;
            r_q    <= 4'h0;
            dz_q   <= 1'b0;
            ovf_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            dvd_q  <= dvd_d;
            rem_q  <= rem_d;
            dvs_q  <= dvs_d;
            cnt_q  <= cnt_d;
            qneg_q <= qneg_d;
            rneg_q <= rneg_d;
            dzp_q  <= dzp_d;
            ovfp_q <= ovfp_d;
            q_q    <= q_d;
            r_q    <= r_d;
            dz_q   <= dz_d;
            ovf_q  <= ovf_d;
            done_q <= done_d;
        end
    end

    assign done = done_q;
    assign q    = q_q;
    assign r    = r_q;
    assign dz   = dz_q;
    assign ovf  = ovf_q;
endmodule

// File: tb/tb_signed_div_8x4.sv
// tb_signed_div_8x4: directed and exhaustive checks of the signed 8x4 divider.
module tb_signed_div_8x4;
    logic       clk = 1'b0;
    logic       rst, start, busy, done, dz, ovf;
    logic [7:0] a, q;
    logic [3:0] b, r;
    int tests = 0;
    int fails = 0;

    signed_div_8x4 dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .q(q), .r(r), .dz(dz), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic do_div(input logic [7:0] ai, input logic [3:0] bi, output int lat);
        @(negedge clk);
        a = ai;
        b = bi;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        a = ~ai;
        b = ~bi;
        lat = 0;
        while (lat < 20) begin
            @(posedge clk);
            #1 lat++;
            if (done) break;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        a = 8'h00;
        b = 4'h0;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if ({busy, done, q, r, dz, ovf} !== 16'h0) begin
            fails++;
            $display("FAIL reset busy=%b done=%b q=%h r=%h dz=%b ovf=%b expected all zero", busy, done, q, r, dz, ovf);
        end
        @(negedge clk) rst = 1'b0;
        @(posedge clk);
        #1;
        tests++;
        if ({busy, done} !== 2'b00) begin
            fails++;
            $display("FAIL reset_idle busy=%b done=%b expected 0 0", busy, done);
        end
    endtask

    task automatic test_basic();
        logic [23:0] vec [7] = '{
            {8'hF4, 4'h6, 8'hFE, 4'h0}, {8'hEC, 4'h6, 8'hFD, 4'hE},
            {8'h64, 4'h9, 8'hF2, 4'h2}, {8'h80, 4'h8, 8'h10, 4'h0},
            {8'h7F, 4'h7, 8'h12, 4'h1}, {8'h07, 4'hE, 8'hFD, 4'h1},
            {8'h00, 4'h5, 8'h00, 4'h0}};
        int lat;
        for (int i = 0; i < 7; i++) begin
            do_div(vec[i][23:16], vec[i][15:12], lat);
            tests++;
            if (lat != 9 || {q, r, dz, ovf} !== {vec[i][11:0], 2'b00}) begin
                fails++;
                $display("FAIL basic%0d lat=%0d q=%h r=%h dz=%b ovf=%b expected lat=9 q=%h r=%h dz=0 ovf=0",
                         i, lat, q, r, dz, ovf, vec[i][11:4], vec[i][3:0]);
            end
            @(posedge clk);
            #1;
            tests++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                fails++;
                $display("FAIL basic%0d_pulse done=%b busy=%b expected 0 0", i, done, busy);
            end
        end
    endtask

    task automatic test_special();
        int lat;
        do_div(8'h80, 4'hF, lat);
        tests++;
        if (lat != 9 || {q, r, dz, ovf} !== {8'h80, 4'h0, 2'b01}) begin
            fails++;
            $display("FAIL ovf lat=%0d q=%h r=%h dz=%b ovf=%b expected lat=9 q=80 r=0 dz=0 ovf=1", lat, q, r, dz, ovf);
        end
        do_div(8'h05, 4'h0, lat);
        tests++;
        if (lat != 9 || {q, r, dz, ovf} !== {8'hFF, 4'h0, 2'b10}) begin
            fails++;
            $display("FAIL dz lat=%0d q=%h r=%h dz=%b ovf=%b expected lat=9 q=ff r=0 dz=1 ovf=0", lat, q, r, dz, ovf);
        end
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if ({q, dz} !== {8'hFF, 1'b1}) begin
            fails++;
            $display("FAIL dz_hold q=%h dz=%b expected q=ff dz=1", q, dz);
        end
    endtask

    task automatic test_ignore_start();
        int cyc;
        @(negedge clk);
        a = 8'hF4;
        b = 4'h6;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        a = 8'h64;
        b = 4'h9;
        repeat (2) @(posedge clk);
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        cyc = 3;
        while (cyc < 25) begin
            @(posedge clk);
            #1 cyc++;
            if (done) break;
        end
        tests++;
        if (cyc != 9 || {q, r, dz, ovf} !== {8'hFE, 4'h0, 2'b00}) begin
            fails++;
            $display("FAIL ignore_start cyc=%0d q=%h r=%h expected cyc=9 q=fe r=0", cyc, q, r);
        end
        @(posedge clk);
        #1;
        tests++;
        if ({busy, done} !== 2'b00) begin
            fails++;
            $display("FAIL ignore_start_idle busy=%b done=%b expected 0 0", busy, done);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        a = 8'hF4;
        b = 4'h6;
        start = 1'b1;
        @(posedge clk);
        #1 a = 8'hEC;
        for (int i = 1; i <= 19; i++) begin
            @(posedge clk);
            #1;
            if (i == 9) begin
                tests++;
                if ({done, q, r} !== {1'b1, 8'hFE, 4'h0}) begin
                    fails++;
                    $display("FAIL b2b_first done=%b q=%h r=%h expected 1 fe 0", done, q, r);
                end
            end
            if (i == 10) begin
                start = 1'b0;
                tests++;
                if ({busy, done} !== 2'b10) begin
                    fails++;
                    $display("FAIL b2b_accept busy=%b done=%b expected 1 0", busy, done);
                end
            end
            if (i == 19) begin
                tests++;
                if ({done, q, r} !== {1'b1, 8'hFD, 4'hE}) begin
                    fails++;
                    $display("FAIL b2b_second done=%b q=%h r=%h expected 1 fd e", done, q, r);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int seen = 0;
        int lat;
        @(negedge clk);
        a = 8'h64;
        b = 4'h9;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        #1;
        tests++;
        if ({busy, done, q, r, dz, ovf} !== 16'h0) begin
            fails++;
            $display("FAIL reset_mid busy=%b done=%b q=%h r=%h dz=%b ovf=%b expected all zero", busy, done, q, r, dz, ovf);
        end
        @(negedge clk) rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1 if (done) seen++;
        end
        tests++;
        if (seen != 0) begin
            fails++;
            $display("FAIL reset_mid_nodone done_pulses=%0d expected 0", seen);
        end
        do_div(8'h7F, 4'h7, lat);
        tests++;
        if (lat != 9 || {q, r, dz, ovf} !== {8'h12, 4'h1, 2'b00}) begin
            fails++;
            $display("FAIL reset_mid_after lat=%0d q=%h r=%h expected lat=9 q=12 r=1", lat, q, r);
        end
    endtask

    task automatic test_sweep();
        int sa, sb, lat, shown;
        logic [7:0] eq;
        logic [3:0] er;
        logic edz, eov;
        shown = 0;
        for (int i = 0; i < 256; i++) begin
            for (int j = 0; j < 16; j++) begin
                sa = i > 127 ? i - 256 : i;
                sb = j > 7 ? j - 16 : j;
                edz = sb == 0;
                eov = sa == -128 && sb == -1;
                eq = edz ? 8'hFF : eov ? 8'h80 : 8'(sa / sb);
                er = (edz || eov) ? 4'h0 : 4'(sa % sb);
                do_div(8'(i), 4'(j), lat);
                tests++;
                if (lat != 9 || {q, r, dz, ovf} !== {eq, er, edz, eov}) begin
                    fails++;
                    if (shown++ < 8)
                        $display("FAIL sweep a=%h b=%h lat=%0d q=%h r=%h dz=%b ovf=%b expected lat=9 q=%h r=%h dz=%b ovf=%b",
                                 8'(i), 4'(j), lat, q, r, dz, ovf, eq, er, edz, eov);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_special();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        test_sweep();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
